mem_port_arbiter: RTL and testbench

// Shares one single-port synchronous RAM between the instruction-fetch path and the

---
 rtl/rv_mem_pkg.sv | 16 +
 rtl/mem_resp_tracker.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the memory port arbiter.
// - mem_owner_e : which requester owns the read response returning next cycle
// - MEM_W_*     : access width codes carried on d_width / ram_width
package rv_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } mem_owner_e;

    localparam logic [1:0] MEM_W_BYTE = 2'b00;
    localparam logic [1:0] MEM_W_HALF = 2'b01;
    localparam logic [1:0] MEM_W_WORD = 2'b10;

endpackage

// File: rtl/mem_resp_tracker.sv
// Tracks which requester owns the RAM read data returning in the next cycle and produces
// the per-requester rvalid strobes.
// Ports:
//   clk_i, rst_sync_i      clock, synchronous active-high reset
//   if_gnt_i, d_gnt_i      grants issued this cycle (already reset-gated by the arbiter)
//   d_we_i                 data access is a store (no read response)
//   flush_i                pipeline flush, kills fetch responses only
//   if_rvalid_o, d_rvalid_o response strobes
module mem_resp_tracker
    import rv_mem_pkg::*;
(
    input  logic clk_i,
    input  logic rst_sync_i,
    input  logic if_gnt_i,
    input  logic d_gnt_i,
    input  logic d_we_i,
    input  logic flush_i,
    output logic if_rvalid_o,
    output logic d_rvalid_o
);

    mem_owner_e owner_q, owner_d;
    logic       drop_q, drop_d;

    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            owner_q <= OWN_NONE;
            drop_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (d_gnt_i && !d_we_i) begin
            owner_d = OWN_D;
        end else if (if_gnt_i) begin
            owner_d = OWN_IF;
        end
        // A flush in the grant cycle itself must kill the response that lands next cycle.
        drop_d = if_gnt_i & flush_i;
    end

    // Gating with reset discards a response that would otherwise land in the reset cycle.
    always_comb begin
        if_rvalid_o = ~rst_sync_i & (owner_q == OWN_IF) & ~flush_i & ~drop_q;
        d_rvalid_o  = ~rst_sync_i & (owner_q == OWN_D);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// Data wins ties, limited to MAX_D_STREAK consecutive grants while fetch waits
// (0 = strict data priority). At most one access is granted per cycle.
// Ports:
//   clk, rst_sync                         clock, synchronous active-high reset
//   if_req/if_addr/if_gnt                 fetch request channel
//   if_rvalid/if_rdata                    fetch response
//   d_req/d_we/d_width/d_addr/d_wdata     load/store request channel
//   d_gnt, d_rvalid/d_rdata               load/store grant and response
//   flush                                 drops in-flight fetch responses
//   stall_n                               low while any asserted request is refused
//   ram_*                                 single-port RAM interface
module mem_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_sync,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_width,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              flush,
    output logic              stall_n,
    output logic              ram_en,
    output logic              ram_we,
    output logic [1:0]        ram_width,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned StreakW = (MAX_D_STREAK == 0) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

    logic [StreakW-1:0] streak_q, streak_d;
    logic               data_ok;

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    // Grant logic: combinational from this cycle's requests, suppressed during reset.
    always_comb begin
        data_ok = (MAX_D_STREAK == 0) || (streak_q < StreakMax);
        d_gnt   = ~rst_sync & d_req & (~if_req | data_ok);
        if_gnt  = ~rst_sync & if_req & ~d_gnt;
        stall_n = rst_sync | ~((if_req & ~if_gnt) | (d_req & ~d_gnt));
    end

    // Streak counts data grants that made fetch wait; saturates at the limit.
    always_comb begin
        streak_d = streak_q;
        if (!if_req || if_gnt) begin
            streak_d = '0;
        end else if (d_gnt && (streak_q < StreakMax)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_comb begin
        ram_en    = if_gnt | d_gnt;
        ram_we    = 1'b0;
        ram_width = MEM_W_WORD;
        ram_addr  = if_addr;
        ram_wdata = '0;
        if (d_gnt) begin
            ram_we    = d_we;
            ram_width = d_width;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end
    end

    assign if_rdata = ram_rdata;
    assign d_rdata  = ram_rdata;

    mem_resp_tracker u_resp_tracker (
        .clk_i       (clk),
        .rst_sync_i  (rst_sync),
        .if_gnt_i    (if_gnt),
        .d_gnt_i     (d_gnt),
        .d_we_i      (d_we),
        .flush_i     (flush),
        .if_rvalid_o (if_rvalid),
        .d_rvalid_o  (d_rvalid)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam logic [31:0] KEY = 32'hDEADBFEF;  // RAM model: rdata = addr ^ KEY

    typedef struct packed {
        logic        we;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ram_rec_t;

    logic        clk = 1'b0;
    logic        rst_sync;
    logic        if_req, d_req, d_we, flush;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [1:0]  d_width;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, stall_n;
    logic [31:0] if_rdata, d_rdata;
    logic        ram_en, ram_we;
    logic [1:0]  ram_width;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    // Second instance: strict data priority
    logic        b_if_req, b_d_req;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_stall_n;
    logic [31:0] b_if_rdata, b_d_rdata;
    logic        b_ram_en, b_ram_we;
    logic [1:0]  b_ram_width;
    logic [31:0] b_ram_addr, b_ram_wdata;
    logic [31:0] b_zero = 32'h0;
    logic [1:0]  b_w = 2'b10;
    logic        b_lo = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [2:0]  cyc_q[$];
    logic [2:0]  cycb_q[$];
    ram_rec_t    ram_q[$];
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en && !ram_we) ram_rdata <= ram_addr ^ KEY;
    end

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst_sync(rst_sync),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .flush(flush), .stall_n(stall_n),
        .ram_en(ram_en), .ram_we(ram_we), .ram_width(ram_width), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(0)) dut_b (
        .clk(clk), .rst_sync(rst_sync),
        .if_req(b_if_req), .if_addr(b_zero), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_lo), .d_width(b_w), .d_addr(b_zero), .d_wdata(b_zero),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .flush(b_lo), .stall_n(b_stall_n),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_width(b_ram_width), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_zero)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant/response
    always @(negedge clk) begin
        logic [2:0] c;
        ram_rec_t   r;
        if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            chk("gnt_if_d_stalln", {61'd0, if_gnt, d_gnt, stall_n}, {61'd0, c});
        end
        if (ram_en) begin
            if (ram_q.size() == 0) begin
                chk("ram_en_unexpected", 64'd1, 64'd0);
            end else begin
                r = ram_q.pop_front();
                chk("ram_we_width_addr", {29'd0, ram_we, ram_width, ram_addr},
                    {29'd0, r.we, r.width, r.addr});
                if (r.we) chk("ram_wdata", {32'd0, ram_wdata}, {32'd0, r.wdata});
            end
        end
        if (if_rvalid) begin
            if (if_q.size() == 0) chk("if_rvalid_unexpected", 64'd1, 64'd0);
            else chk("if_rdata", {32'd0, if_rdata}, {32'd0, if_q.pop_front()});
        end
        if (d_rvalid) begin
            if (d_q.size() == 0) chk("d_rvalid_unexpected", 64'd1, 64'd0);
            else chk("d_rdata", {32'd0, d_rdata}, {32'd0, d_q.pop_front()});
        end
        if (cycb_q.size() > 0) begin
            c = cycb_q.pop_front();
            chk("b_gnt_if_d_stalln", {61'd0, b_if_gnt, b_d_gnt, b_stall_n}, {61'd0, c});
        end
    end

    // Push expectations for the cycle whose inputs are currently driven, then advance.
    task automatic step(input logic eig, input logic edg, input logic est,
                        input logic want_if, input logic want_d);
        ram_rec_t r;
        cyc_q.push_back({eig, edg, est});
        if (eig) begin
            r.we = 1'b0; r.width = 2'b10; r.addr = if_addr; r.wdata = 32'h0;
            ram_q.push_back(r);
            if (want_if) if_q.push_back(if_addr ^ KEY);
        end
        if (edg) begin
            r.we = d_we; r.width = d_width; r.addr = d_addr; r.wdata = d_wdata;
            ram_q.push_back(r);
            if (want_d) d_q.push_back(d_addr ^ KEY);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_sync = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; flush = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_width = 2'b10;
        b_if_req = 1'b0; b_d_req = 1'b0;
        @(posedge clk);
        #1;
        // Reset with requests asserted: nothing granted, stall_n high
        if_req = 1'b1; d_req = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_sync = 1'b0; if_req = 1'b0; d_req = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 1: single fetch at 0x100, data 0xDEADBEEF next cycle
        if_req = 1'b1; if_addr = 32'h100;
        if_q.push_back(32'hDEADBEEF);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        if_req = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 2: both requesting every cycle -> 4 data, 1 fetch, repeating
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_width = 2'b10; d_addr = 32'h1000;
        for (int i = 0; i < 10; i++) begin
            step((i % 5) == 4, (i % 5) != 4, 1'b0, 1'b1, 1'b1);
        end
        if_req = 1'b0; d_req = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 3: byte store, no response afterwards
        d_req = 1'b1; d_we = 1'b1; d_width = 2'b00; d_addr = 32'h2003; d_wdata = 32'hAB;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        d_req = 1'b0; d_we = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 4: flush in grant cycle, then flush in response cycle
        if_req = 1'b1; if_addr = 32'h300; flush = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        if_req = 1'b0; flush = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        if_req = 1'b1; if_addr = 32'h400;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        if_req = 1'b0; flush = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        flush = 1'b0; if_req = 1'b1; if_addr = 32'h500;
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        if_req = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 5: build a streak, reset right after a load grant, streak restarts from 0
        if_req = 1'b1; if_addr = 32'h600; d_req = 1'b1; d_addr = 32'h3000; d_width = 2'b10;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_sync = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_sync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(i == 4, i != 4, 1'b0, 1'b1, 1'b1);
        end
        if_req = 1'b0; d_req = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 6: strict data priority instance, both requesting for 10 cycles
        b_if_req = 1'b1; b_d_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycb_q.push_back(3'b010);
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        b_if_req = 1'b0; b_d_req = 1'b0;
        cycb_q.push_back(3'b001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        chk("if_resp_outstanding", {32'd0, if_q.size()}, 64'd0);
        chk("d_resp_outstanding", {32'd0, d_q.size()}, 64'd0);
        chk("ram_acc_outstanding", {32'd0, ram_q.size()}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
